// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared frame constants, FSM encoding and default servo angles
package servo_pkg;

  localparam logic [7:0] HDR        = 8'hA5;
  localparam logic [7:0] CMD_SET    = 8'h01;
  localparam logic [7:0] CMD_SCAN   = 8'h02;
  localparam logic [7:0] CMD_CENTER = 8'h03;
  localparam logic [7:0] CMD_HOLD   = 8'h04;
  localparam int         MAX_DEG    = 180;

  // Defaults shared with the PWM generator
  localparam int ANGLE_MIN_DEF      = 23000;
  localparam int ANGLE_MAX_DEF      = 127000;
  localparam int ANGLE_CENTER_DEF   = 75002;
  localparam int STEP_PER_DEG_DEF   = 578;
  localparam int TIMEOUT_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ARG,
    ST_GET_CHK
  } state_t;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_SET) || (c == CMD_SCAN) || (c == CMD_CENTER) || (c == CMD_HOLD);
  endfunction

endpackage

// File: rtl/servo_deg_to_count.sv
// rtl/servo_deg_to_count.sv - combinational degree to pulse-count conversion with ceiling clamp
module servo_deg_to_count import servo_pkg::*; #(
  parameter int ANGLE_MIN    = ANGLE_MIN_DEF,
  parameter int ANGLE_MAX    = ANGLE_MAX_DEF,
  parameter int STEP_PER_DEG = STEP_PER_DEG_DEF
) (
  input  logic [7:0]  deg,
  output logic [16:0] count
);

  localparam logic [17:0] MIN18  = 18'(ANGLE_MIN);
  localparam logic [17:0] MAX18  = 18'(ANGLE_MAX);
  localparam logic [9:0]  STEP10 = 10'(STEP_PER_DEG);

  logic [17:0] product;
  logic [17:0] sum;

  // 8x10 product fits in 18 bits, so the add and compare cannot wrap for any byte
  always_comb begin
    product = 18'(deg) * 18'(STEP10);
    sum     = MIN18 + product;
    if (sum > MAX18) begin
      count = MAX18[16:0];
    end else begin
      count = sum[16:0];
    end
  end

endmodule

// File: rtl/servo_cmd_decoder.sv
// rtl/servo_cmd_decoder.sv - parses A5/CMD/ARG/CHK frames from the UART and drives the servo PWM controls
module servo_cmd_decoder import servo_pkg::*; #(
  parameter int ANGLE_MIN      = ANGLE_MIN_DEF,
  parameter int ANGLE_MAX      = ANGLE_MAX_DEF,
  parameter int ANGLE_CENTER   = ANGLE_CENTER_DEF,
  parameter int STEP_PER_DEG   = STEP_PER_DEG_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk3,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [16:0] angle_fb,
  output logic        holder,
  output logic        tune,
  output logic [16:0] lock,
  output logic        cmd_ack,
  output logic        frame_err
);

  localparam int          CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] CENTER17 = 17'(ANGLE_CENTER);

  state_t      state, state_nxt;
  logic [7:0]  cmd, cmd_nxt;
  logic [7:0]  arg, arg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic        holder_nxt, tune_nxt, ack_nxt, err_nxt;
  logic [16:0] lock_nxt;
  logic [16:0] set_count;

  servo_deg_to_count #(
    .ANGLE_MIN    (ANGLE_MIN),
    .ANGLE_MAX    (ANGLE_MAX),
    .STEP_PER_DEG (STEP_PER_DEG)
  ) u_deg_to_count (
    .deg   (arg),
    .count (set_count)
  );

  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd       <= '0;
      arg       <= '0;
      cnt       <= '0;
      holder    <= 1'b0;
      tune      <= 1'b1;
      lock      <= CENTER17;
      cmd_ack   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd       <= cmd_nxt;
      arg       <= arg_nxt;
      cnt       <= cnt_nxt;
      holder    <= holder_nxt;
      tune      <= tune_nxt;
      lock      <= lock_nxt;
      cmd_ack   <= ack_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_nxt    = cmd;
    arg_nxt    = arg;
    cnt_nxt    = cnt;
    holder_nxt = holder;
    tune_nxt   = tune;
    lock_nxt   = lock;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;

    if (state == ST_IDLE) begin
      if (rx_valid) begin
        cnt_nxt = '0;
        if (rx_data == HDR) begin
          state_nxt = ST_GET_CMD;
        end
      end
    end else if (rx_valid) begin
      // A byte in the timeout cycle wins over the timeout
      cnt_nxt = '0;
      case (state)
        ST_GET_CMD: begin
          cmd_nxt   = rx_data;
          state_nxt = ST_GET_ARG;
        end
        ST_GET_ARG: begin
          arg_nxt   = rx_data;
          state_nxt = ST_GET_CHK;
        end
        default: begin
          state_nxt = ST_IDLE;
          if ((rx_data != (cmd ^ arg)) || !cmd_known(cmd) ||
              ((cmd == CMD_SET) && (arg > 8'(MAX_DEG)))) begin
            err_nxt = 1'b1;
          end else begin
            ack_nxt = 1'b1;
            case (cmd)
              CMD_SET: begin
                lock_nxt   = set_count;
                holder_nxt = 1'b1;
                tune_nxt   = 1'b0;
              end
              CMD_SCAN: begin
                holder_nxt = 1'b0;
                tune_nxt   = 1'b0;
              end
              CMD_CENTER: begin
                lock_nxt   = CENTER17;
                holder_nxt = 1'b0;
                tune_nxt   = 1'b1;
              end
              default: begin
                lock_nxt   = angle_fb;
                holder_nxt = 1'b1;
                tune_nxt   = 1'b0;
              end
            endcase
          end
        end
      endcase
    end else if (cnt == CNT_LAST) begin
      cnt_nxt   = '0;
      err_nxt   = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_servo_cmd_decoder.sv
// tb/tb_servo_cmd_decoder.sv - randomized frame stimulus against a queue-based reference model
module tb_servo_cmd_decoder;

  localparam int TMO    = 16;
  localparam int AMIN   = 23000;
  localparam int AMAX   = 127000;
  localparam int ACTR   = 75002;
  localparam int STEP   = 578;

  logic        clk3 = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [16:0] angle_fb;
  logic        holder, tune, cmd_ack, frame_err;
  logic [16:0] lock;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  int cycle = 0;

  int exp_holder, exp_tune, exp_lock, exp_ack, exp_err;
  logic [7:0] fq[$];
  int idle_run;

  servo_cmd_decoder #(
    .ANGLE_MIN      (AMIN),
    .ANGLE_MAX      (AMAX),
    .ANGLE_CENTER   (ACTR),
    .STEP_PER_DEG   (STEP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk3      (clk3),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .angle_fb  (angle_fb),
    .holder    (holder),
    .tune      (tune),
    .lock      (lock),
    .cmd_ack   (cmd_ack),
    .frame_err (frame_err)
  );

  always #5 clk3 = ~clk3;

  // Reference model: a frame is just the list of bytes collected since the header
  initial begin
    exp_holder = 0; exp_tune = 1; exp_lock = ACTR; exp_ack = 0; exp_err = 0;
    idle_run = 0;
    forever begin
      @(posedge clk3 or negedge rst_n);
      if (!rst_n) begin
        exp_holder = 0; exp_tune = 1; exp_lock = ACTR; exp_ack = 0; exp_err = 0;
        fq.delete();
        idle_run = 0;
      end else begin
        exp_ack = 0;
        exp_err = 0;
        if (fq.size() == 0) begin
          if (rx_valid && rx_data == 8'hA5) begin
            fq.push_back(rx_data);
            idle_run = 0;
          end
        end else if (rx_valid) begin
          fq.push_back(rx_data);
          idle_run = 0;
          if (fq.size() == 4) begin
            int c, a, k;
            c = fq[1]; a = fq[2]; k = fq[3];
            if (k != (c ^ a) || c < 1 || c > 4 || (c == 1 && a > 180)) begin
              exp_err = 1;
            end else begin
              exp_ack = 1;
              if (c == 1) begin
                exp_lock = AMIN + a * STEP;
                if (exp_lock > AMAX) exp_lock = AMAX;
                exp_holder = 1; exp_tune = 0;
              end else if (c == 2) begin
                exp_holder = 0; exp_tune = 0;
              end else if (c == 3) begin
                exp_lock = ACTR; exp_holder = 0; exp_tune = 1;
              end else begin
                exp_lock = int'(angle_fb); exp_holder = 1; exp_tune = 0;
              end
            end
            fq.delete();
          end
        end else begin
          idle_run++;
          if (idle_run == TMO) begin
            exp_err = 1;
            fq.delete();
            idle_run = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare and pulse counting
  initial begin
    forever begin
      @(negedge clk3);
      cycle++;
      if (cmd_ack) ack_cnt++;
      if (frame_err) err_cnt++;
      checks++;
      if (int'(holder) != exp_holder || int'(tune) != exp_tune || int'(lock) != exp_lock ||
          int'(cmd_ack) != exp_ack || int'(frame_err) != exp_err || (cmd_ack && frame_err)) begin
        errors++;
        $display("FAIL model cycle %0d: got h=%0d t=%0d lock=%0d ack=%0d err=%0d, want h=%0d t=%0d lock=%0d ack=%0d err=%0d",
                 cycle, holder, tune, lock, cmd_ack, frame_err,
                 exp_holder, exp_tune, exp_lock, exp_ack, exp_err);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk3);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk3);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
  endtask

  initial begin
    int a0, e0;
    logic [7:0] c, a, k;
    int kind;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; angle_fb = 17'd0;
    idle(3);
    rst_n = 1'b1;
    idle(5);
    chk("reset_holder", int'(holder), 0);
    chk("reset_tune", int'(tune), 1);
    chk("reset_lock", int'(lock), 75002);
    chk("reset_pulses", ack_cnt + err_cnt, 0);

    a0 = ack_cnt; e0 = err_cnt;
    send_frame(8'hA5, 8'h01, 8'h5A, 8'h5B); idle(2);
    chk("deg90_lock", int'(lock), 75020);
    chk("deg90_holder", int'(holder), 1);
    chk("deg90_tune", int'(tune), 0);
    chk("deg90_ack", ack_cnt - a0, 1);

    send_frame(8'hA5, 8'h01, 8'hB4, 8'hB5); idle(2);
    chk("deg180_clamp", int'(lock), 127000);
    send_frame(8'hA5, 8'h01, 8'h00, 8'h01); idle(2);
    chk("deg0_lock", int'(lock), 23000);

    a0 = ack_cnt; e0 = err_cnt;
    send_frame(8'hA5, 8'h01, 8'h5A, 8'h00); idle(2);
    chk("badchk_err", err_cnt - e0, 1);
    chk("badchk_lock", int'(lock), 23000);
    send_frame(8'hA5, 8'h01, 8'hB5, 8'hB4); idle(2);
    chk("deg181_err", err_cnt - e0, 2);
    chk("bad_no_ack", ack_cnt - a0, 0);

    angle_fb = 17'd40556;
    send_frame(8'hA5, 8'h04, 8'h00, 8'h04); idle(2);
    chk("hold_lock", int'(lock), 40556);
    chk("hold_holder", int'(holder), 1);
    angle_fb = 17'd99;
    send_frame(8'hA5, 8'h02, 8'h00, 8'h02); idle(2);
    chk("scan_holder", int'(holder), 0);
    chk("scan_tune", int'(tune), 0);
    chk("scan_lock", int'(lock), 40556);

    e0 = err_cnt; a0 = ack_cnt;
    send_byte(8'hA5); send_byte(8'h01);
    idle(15);
    chk("timeout_early", err_cnt - e0, 0);
    idle(5);
    chk("timeout_err", err_cnt - e0, 1);
    send_frame(8'hA5, 8'h03, 8'h07, 8'h04); idle(2);
    chk("after_timeout_ack", ack_cnt - a0, 1);
    chk("center_tune", int'(tune), 1);

    send_frame(8'hA5, 8'h01, 8'h5A, 8'h5B); idle(2);
    a0 = ack_cnt;
    send_byte(8'hA5); send_byte(8'h01);
    rst_n = 1'b0;
    #1;
    chk("midreset_lock", int'(lock), 75002);
    chk("midreset_holder", int'(holder), 0);
    chk("midreset_tune", int'(tune), 1);
    @(negedge clk3);
    rst_n = 1'b1;
    send_byte(8'h5A); send_byte(8'h5B); idle(3);
    chk("midreset_no_ack", ack_cnt - a0, 0);
    chk("midreset_lock_kept", int'(lock), 75002);

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 1) begin
        send_byte(8'($urandom));
        idle($urandom_range(0, 2));
      end else begin
        c = 8'($urandom_range(0, 5));
        a = (c == 8'h01) ? 8'($urandom_range(0, 200)) : 8'($urandom);
        k = c ^ a;
        if (kind == 0) k = k ^ (8'h01 << $urandom_range(0, 7));
        angle_fb = 17'($urandom_range(0, 131071));
        send_byte(8'hA5);
        idle($urandom_range(0, 1));
        send_byte(c);
        if (kind == 2) idle($urandom_range(14, 17));
        angle_fb = 17'($urandom_range(0, 131071));
        send_byte(a);
        idle($urandom_range(0, 1));
        send_byte(k);
        idle($urandom_range(0, 2));
      end
    end
    idle(TMO + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
